// File: rtl/poly_voice_allocator.sv
// Polyphonic key-to-voice allocator: per-key sync + debounce, event queue,
// voice assignment with oldest-voice stealing.
//
// Ports:
//   clk_in           system clock
//   rst_n_in         asynchronous active-low reset
//   key_in           raw key levels, 1 = pressed, asynchronous
//   note_out         voice v note index at [v*KEY_W +: KEY_W]
//   gate_out         1 while voice v holds a key
//   trigger_out      one-cycle pulse when voice v is (re)assigned
//   active_count_out number of gated voices (registered)
module poly_voice_allocator #(
    parameter int NUM_KEYS        = 16,
    parameter int NUM_VOICES      = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    localparam int KEY_W = $clog2(NUM_KEYS),
    localparam int AGE_W = $clog2(NUM_VOICES),
    localparam int CNT_W = $clog2(NUM_VOICES + 1),
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [NUM_KEYS-1:0]         key_in,
    output logic [NUM_VOICES*KEY_W-1:0] note_out,
    output logic [NUM_VOICES-1:0]       gate_out,
    output logic [NUM_VOICES-1:0]       trigger_out,
    output logic [CNT_W-1:0]            active_count_out
);

    logic [NUM_KEYS-1:0] sync1, sync2, clean, clean_d;
    logic [DB_W-1:0]     db_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] press_pend, release_pend;
    logic [NUM_KEYS-1:0] press_nxt, release_nxt;
    logic [NUM_KEYS-1:0] rise, fall;
    logic [NUM_KEYS-1:0] rel_mask, prs_mask, svc_mask;
    logic                is_rel, is_prs;
    logic [KEY_W-1:0]    svc_key;

    logic [KEY_W-1:0]      note_r [NUM_VOICES];
    logic [KEY_W-1:0]      note_n [NUM_VOICES];
    logic [AGE_W-1:0]      age_r  [NUM_VOICES];
    logic [AGE_W-1:0]      age_n  [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_r, gate_n, trig_r, trig_n;
    logic [NUM_VOICES-1:0] tgt_mask;
    logic [AGE_W-1:0]      tgt_age;
    logic                  have_free;
    logic [CNT_W-1:0]      cnt_r, cnt_n;

    // Synchroniser and per-key debouncer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1   <= '0;
            sync2   <= '0;
            clean   <= '0;
            clean_d <= '0;
            for (int k = 0; k < NUM_KEYS; k++) db_cnt[k] <= '0;
        end else begin
            sync1   <= key_in;
            sync2   <= sync1;
            clean_d <= clean;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (sync2[k] == clean[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt[k] <= '0;
                    clean[k]  <= ~clean[k];
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign rise = clean & ~clean_d;
    assign fall = ~clean & clean_d;

    // Event selection: releases beat presses, lowest key first.
    // x & -x isolates the lowest set bit.
    always_comb begin
        rel_mask = release_pend & (~release_pend + 1'b1);
        prs_mask = press_pend & (~press_pend + 1'b1);
        is_rel   = |release_pend;
        is_prs   = !is_rel && (|press_pend);
        svc_mask = is_rel ? rel_mask : prs_mask;
        svc_key  = '0;
        for (int k = 0; k < NUM_KEYS; k++)
            if (svc_mask[k]) svc_key = KEY_W'(k);
        press_nxt   = press_pend;
        release_nxt = release_pend;
        if (is_rel) release_nxt = release_nxt & ~svc_mask;
        if (is_prs) press_nxt   = press_nxt & ~svc_mask;
        // New edges applied after the clear so the latest event wins.
        press_nxt   = (press_nxt | rise) & ~fall;
        release_nxt = (release_nxt | fall) & ~rise;
    end

    // Target voice: lowest free, else the oldest (age == NUM_VOICES-1).
    always_comb begin
        tgt_mask  = '0;
        tgt_age   = '0;
        have_free = 1'b0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!gate_r[v]) begin
                tgt_mask  = '0;
                tgt_mask[v] = 1'b1;
                tgt_age   = age_r[v];
                have_free = 1'b1;
            end
        end
        if (!have_free) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (age_r[v] == AGE_W'(NUM_VOICES - 1)) begin
                    tgt_mask    = '0;
                    tgt_mask[v] = 1'b1;
                    tgt_age     = age_r[v];
                end
            end
        end
    end

    always_comb begin
        gate_n = gate_r;
        trig_n = '0;
        cnt_n  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            note_n[v] = note_r[v];
            age_n[v]  = age_r[v];
        end
        if (is_rel) begin
            for (int v = 0; v < NUM_VOICES; v++)
                if (gate_r[v] && note_r[v] == svc_key) gate_n[v] = 1'b0;
        end
        if (is_prs) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (tgt_mask[v]) begin
                    note_n[v] = svc_key;
                    gate_n[v] = 1'b1;
                    trig_n[v] = 1'b1;
                    age_n[v]  = '0;
                end else if (age_r[v] < tgt_age) begin
                    age_n[v] = age_r[v] + 1'b1;
                end
            end
        end
        for (int v = 0; v < NUM_VOICES; v++)
            cnt_n = cnt_n + CNT_W'(gate_n[v]);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            press_pend   <= '0;
            release_pend <= '0;
            gate_r       <= '0;
            trig_r       <= '0;
            cnt_r        <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_r[v] <= '0;
                age_r[v]  <= AGE_W'(v);
            end
        end else begin
            press_pend   <= press_nxt;
            release_pend <= release_nxt;
            gate_r       <= gate_n;
            trig_r       <= trig_n;
            cnt_r        <= cnt_n;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_r[v] <= note_n[v];
                age_r[v]  <= age_n[v];
            end
        end
    end

    always_comb begin
        note_out = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            note_out[v*KEY_W +: KEY_W] = note_r[v];
    end

    assign gate_out         = gate_r;
    assign trigger_out      = trig_r;
    assign active_count_out = cnt_r;

endmodule

// File: tb/tb_poly_voice_allocator.sv
// Scoreboard bench for poly_voice_allocator (DEBOUNCE_CYCLES=4,
// 16 keys, 4 voices); expected events are hand-computed.
module tb_poly_voice_allocator;

    typedef struct {
        int         cyc;
        logic [3:0] gate;
        logic [3:0] trig;
        logic [15:0] notes;
        logic [2:0] cnt;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [15:0] key_in = '0;
    logic [15:0] note_out;
    logic [3:0]  gate_out;
    logic [3:0]  trigger_out;
    logic [2:0]  active_count_out;

    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;
    int   t;
    exp_t q[$];
    logic [3:0] prev_gate = '0;

    poly_voice_allocator #(
        .NUM_KEYS(16),
        .NUM_VOICES(4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .key_in(key_in),
        .note_out(note_out),
        .gate_out(gate_out),
        .trigger_out(trigger_out),
        .active_count_out(active_count_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic push(input int c, input logic [3:0] g,
                        input logic [3:0] tr, input logic [15:0] n,
                        input logic [2:0] a);
        exp_t e;
        e.cyc = c; e.gate = g; e.trig = tr; e.notes = n; e.cnt = a;
        q.push_back(e);
    endtask

    task automatic drive(input logic [15:0] k, output int tt);
        @(negedge clk_in);
        key_in = k;
        tt = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (gate_out !== 4'b0 || trigger_out !== 4'b0 ||
            note_out !== 16'h0 || active_count_out !== 3'd0) begin
            failed++;
            $display("FAIL %s gate=%b trig=%b notes=%h cnt=%0d required all 0",
                     name, gate_out, trigger_out, note_out, active_count_out);
        end
    endtask

    // Monitor: any gate change or trigger is an output event.
    always @(negedge clk_in) begin
        exp_t e;
        if (!rst_n_in) begin
            prev_gate = '0;
        end else if (gate_out != prev_gate || trigger_out != 4'b0) begin
            tests++;
            if (q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_event cyc=%0d gate=%b trig=%b notes=%h cnt=%0d",
                         cyc, gate_out, trigger_out, note_out, active_count_out);
            end else begin
                e = q.pop_front();
                if (cyc != e.cyc || gate_out !== e.gate ||
                    trigger_out !== e.trig || note_out !== e.notes ||
                    active_count_out !== e.cnt) begin
                    failed++;
                    $display("FAIL event got cyc=%0d gate=%b trig=%b notes=%h cnt=%0d required cyc=%0d gate=%b trig=%b notes=%h cnt=%0d",
                             cyc, gate_out, trigger_out, note_out,
                             active_count_out, e.cyc, e.gate, e.trig,
                             e.notes, e.cnt);
                end
            end
            prev_gate = gate_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle(3);
        check_zero("reset_state");
        rst_n_in = 1'b1;
        idle(2);
        check_zero("after_reset_idle");

        // Single press and release of key 3.
        drive(16'h0008, t);
        push(t + 8, 4'b0001, 4'b0001, 16'h0003, 3'd1);
        idle(14);
        drive(16'h0000, t);
        push(t + 8, 4'b0000, 4'b0000, 16'h0003, 3'd0);
        idle(14);

        // Bounce on key 5: stable runs of at most 2 cycles.
        for (int i = 0; i < 40; i++) begin
            key_in = (i % 3 != 2) ? 16'h0020 : 16'h0000;
            @(negedge clk_in);
        end
        key_in = '0;
        idle(14);

        // Keys 2, 9, 4 together.
        drive(16'h0214, t);
        push(t + 8,  4'b0001, 4'b0001, 16'h0002, 3'd1);
        push(t + 9,  4'b0011, 4'b0010, 16'h0042, 3'd2);
        push(t + 10, 4'b0111, 4'b0100, 16'h0942, 3'd3);
        idle(16);
        drive(16'h0000, t);
        push(t + 8,  4'b0110, 4'b0000, 16'h0942, 3'd2);
        push(t + 9,  4'b0100, 4'b0000, 16'h0942, 3'd1);
        push(t + 10, 4'b0000, 4'b0000, 16'h0942, 3'd0);
        idle(16);

        // Fill all voices then steal with key 7.
        drive(16'h0001, t);
        push(t + 8, 4'b0001, 4'b0001, 16'h0940, 3'd1);
        idle(14);
        drive(16'h0003, t);
        push(t + 8, 4'b0011, 4'b0010, 16'h0910, 3'd2);
        idle(14);
        drive(16'h0007, t);
        push(t + 8, 4'b0111, 4'b0100, 16'h0210, 3'd3);
        idle(14);
        drive(16'h000F, t);
        push(t + 8, 4'b1111, 4'b1000, 16'h3210, 3'd4);
        idle(14);
        drive(16'h008F, t);
        push(t + 8, 4'b1111, 4'b0001, 16'h3217, 3'd4);
        idle(14);
        // Release of stolen key 0: no event.
        drive(16'h008E, t);
        idle(14);

        // Release key 1 and press key 8 together.
        drive(16'h018C, t);
        push(t + 8, 4'b1101, 4'b0000, 16'h3217, 3'd3);
        push(t + 9, 4'b1111, 4'b0010, 16'h3287, 3'd4);
        idle(14);

        // Down to 3 gates, queue 2 presses, reset before service.
        drive(16'h008C, t);
        push(t + 8, 4'b1101, 4'b0000, 16'h3287, 3'd3);
        idle(14);
        drive(16'h0C8C, t);
        idle(7);
        #2 rst_n_in = 1'b0;
        #1 check_zero("async_reset");
        key_in = 16'h0400;
        idle(2);
        check_zero("held_in_reset");
        rst_n_in = 1'b1;
        t = cyc;
        push(t + 8, 4'b0001, 4'b0001, 16'h000A, 3'd1);
        idle(20);

        tests++;
        if (q.size() != 0) begin
            failed++;
            $display("FAIL missing_events got %0d left required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
